// File: rtl/video_term_ctrl.sv
// Character-terminal controller: turns a byte stream into character-RAM writes,
// cursor movement, ring-buffer scrolling with bottom-line clears, and full clears.
module video_term_ctrl #(
   parameter int          COLS           = 40,
   parameter int          ROWS           = 25,
   parameter int          RAM_SIZE       = 1000,
   parameter logic [7:0]  FILL_CHAR      = 8'h00,
   parameter int          VSCROLL_CYCLES = 4,
   parameter int          CLEAR_CYCLES   = 1002
) (
   input  logic       cpu_clk,
   input  logic       reset_n,
   input  logic       char_valid,
   input  logic [7:0] char_data,
   output logic       char_ready,
   output logic       video_ce,
   output logic       video_we,
   output logic [9:0] video_addr,
   output logic [7:0] video_data,
   output logic       video_vscroll,
   output logic       video_clear,
   output logic [5:0] cursor_col,
   output logic [4:0] cursor_row,
   output logic       busy
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WRITE  = 3'd1,
      ST_SCROLL = 3'd2,
      ST_LCLR   = 3'd3,
      ST_CLEAR  = 3'd4
   } state_t;

   localparam logic [5:0]  LAST_COL = 6'(COLS - 1);
   localparam logic [4:0]  LAST_ROW = 5'(ROWS - 1);
   localparam logic [9:0]  COLS10   = 10'(COLS);
   localparam logic [9:0]  BASE_MAX = 10'(RAM_SIZE - COLS);
   localparam logic [10:0] RAM11    = 11'(RAM_SIZE);
   localparam logic [10:0] VS_LAST  = 11'(VSCROLL_CYCLES - 1);
   localparam logic [10:0] CLR_LOAD = 11'(CLEAR_CYCLES);
   localparam logic [10:0] LCLR_END = 11'(COLS - 1);

   // Screen position to RAM address, folded once around the ring.
   function automatic logic [9:0] ram_addr(input logic [9:0] b, input logic [4:0] r,
                                           input logic [5:0] c);
      logic [10:0] lin;
      lin = 11'(b) + 11'(r) * 11'(COLS) + 11'(c);
      return (lin >= RAM11) ? 10'(lin - RAM11) : lin[9:0];
   endfunction

   state_t      state_r, state_n;
   logic [5:0]  col_r, col_n;
   logic [4:0]  row_r, row_n;
   logic [9:0]  base_r, base_n;
   logic [10:0] cnt_r, cnt_n;
   logic        we_r, we_n;
   logic [9:0]  addr_r, addr_n;
   logic [7:0]  data_r, data_n;
   logic        vscroll_r, vscroll_n;
   logic        clear_r, clear_n;
   logic        newline_s;

   // Next-state, cursor, ring base and next registered output values.
   always_comb begin
      state_n   = state_r;
      col_n     = col_r;
      row_n     = row_r;
      base_n    = base_r;
      cnt_n     = cnt_r;
      we_n      = 1'b0;
      addr_n    = addr_r;
      data_n    = 8'h00;
      clear_n   = 1'b0;
      newline_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (char_valid) begin
               if (char_data >= 8'h20) begin
                  state_n = ST_WRITE;
                  we_n    = 1'b1;
                  addr_n  = ram_addr(base_r, row_r, col_r);
                  data_n  = char_data;
               end else begin
                  case (char_data)
                     8'h0D:   col_n = 6'd0;
                     8'h0A:   newline_s = 1'b1;
                     8'h08:   col_n = (col_r != 6'd0) ? col_r - 6'd1 : col_r;
                     8'h0C: begin
                        state_n = ST_CLEAR;
                        clear_n = 1'b1;
                        cnt_n   = CLR_LOAD;
                     end
                     default: col_n = col_r;
                  endcase
               end
            end else begin
               state_n = ST_IDLE;
            end
         end
         ST_WRITE: begin
            if (col_r != LAST_COL) begin
               col_n   = col_r + 6'd1;
               state_n = ST_IDLE;
            end else begin
               col_n     = 6'd0;
               newline_s = 1'b1;
            end
         end
         ST_SCROLL: begin
            if (cnt_r == 11'd0) begin
               base_n  = (base_r == BASE_MAX) ? 10'd0 : base_r + COLS10;
               state_n = ST_LCLR;
               cnt_n   = 11'd0;
               we_n    = 1'b1;
               addr_n  = ram_addr(base_n, LAST_ROW, 6'd0);
               data_n  = FILL_CHAR;
            end else begin
               cnt_n = cnt_r - 11'd1;
            end
         end
         // cnt_r is the column currently on the write port.
         ST_LCLR: begin
            if (cnt_r == LCLR_END) begin
               state_n = ST_IDLE;
            end else begin
               cnt_n  = cnt_r + 11'd1;
               we_n   = 1'b1;
               addr_n = ram_addr(base_r, LAST_ROW, cnt_r[5:0] + 6'd1);
               data_n = FILL_CHAR;
            end
         end
         ST_CLEAR: begin
            if (cnt_r == 11'd0) begin
               state_n = ST_IDLE;
               col_n   = 6'd0;
               row_n   = 5'd0;
            end else begin
               cnt_n = cnt_r - 11'd1;
            end
         end
         default: state_n = ST_IDLE;
      endcase
      if (newline_s) begin
         if (row_r != LAST_ROW) begin
            row_n   = row_r + 5'd1;
            state_n = ST_IDLE;
         end else begin
            state_n = ST_SCROLL;
            cnt_n   = VS_LAST;
         end
      end else begin
         row_n = row_n;
      end
      vscroll_n = (state_n == ST_SCROLL);
   end

   // State, cursor, base and output registers.
   always_ff @(posedge cpu_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r   <= ST_IDLE;
         col_r     <= 6'd0;
         row_r     <= 5'd0;
         base_r    <= 10'd0;
         cnt_r     <= 11'd0;
         we_r      <= 1'b0;
         addr_r    <= 10'd0;
         data_r    <= 8'h00;
         vscroll_r <= 1'b0;
         clear_r   <= 1'b0;
      end else begin
         state_r   <= state_n;
         col_r     <= col_n;
         row_r     <= row_n;
         base_r    <= base_n;
         cnt_r     <= cnt_n;
         we_r      <= we_n;
         addr_r    <= addr_n;
         data_r    <= data_n;
         vscroll_r <= vscroll_n;
         clear_r   <= clear_n;
      end
   end

   assign char_ready    = (state_r == ST_IDLE);
   assign busy          = (state_r != ST_IDLE);
   assign video_ce      = we_r;
   assign video_we      = we_r;
   assign video_addr    = addr_r;
   assign video_data    = data_r;
   assign video_vscroll = vscroll_r;
   assign video_clear   = clear_r;
   assign cursor_col    = col_r;
   assign cursor_row    = row_r;

endmodule

// File: tb/tb_video_term_ctrl.sv
// Self-checking bench for video_term_ctrl: directed table, corner sequences and
// random bytes against a screen-level reference model.
module tb_video_term_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       char_valid;
   logic [7:0] char_data;
   logic       char_ready, video_ce, video_we, video_vscroll, video_clear, busy;
   logic [9:0] video_addr;
   logic [7:0] video_data;
   logic [5:0] cursor_col;
   logic [4:0] cursor_row;

   video_term_ctrl dut (
      .cpu_clk(clk), .reset_n(rst_n), .char_valid(char_valid), .char_data(char_data),
      .char_ready(char_ready), .video_ce(video_ce), .video_we(video_we),
      .video_addr(video_addr), .video_data(video_data), .video_vscroll(video_vscroll),
      .video_clear(video_clear), .cursor_col(cursor_col), .cursor_row(cursor_row),
      .busy(busy)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   logic [17:0] got_q[$];
   logic [17:0] exp_q[$];
   int vs_cnt = 0, clr_cnt = 0, bad_idle = 0, exp_vs = 0, exp_clr = 0;
   int m_col = 0, m_row = 0, m_base = 0;

   typedef struct {
      logic [7:0] ch;
      int col;
      int row;
      int nw;
      int addr;
      int data;
   } vec_t;
   vec_t tbl[11];
   logic [7:0] burst[5];

   // Bus monitor: records writes and pulse activity away from the clock edge.
   always @(negedge clk) begin
      if (video_we) got_q.push_back({video_addr, video_data});
      if (video_vscroll) vs_cnt++;
      if (video_clear) clr_cnt++;
      if (video_we != video_ce) bad_idle++;
      else if (!video_we && video_data != 8'h00) bad_idle++;
   end

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s actual=%0d (0x%0h) required=%0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic newline_m();
      if (m_row < 24) m_row++;
      else begin
         exp_vs += 4;
         m_base = (m_base + 40) % 1000;
         for (int c = 0; c < 40; c++) exp_q.push_back({10'((m_base + 960 + c) % 1000), 8'h00});
      end
   endtask

   task automatic model_accept(input logic [7:0] b);
      if (b >= 8'h20) begin
         exp_q.push_back({10'((m_base + m_row * 40 + m_col) % 1000), b});
         if (m_col < 39) m_col++;
         else begin
            m_col = 0;
            newline_m();
         end
      end else if (b == 8'h0D) m_col = 0;
      else if (b == 8'h0A) newline_m();
      else if (b == 8'h08) begin
         if (m_col > 0) m_col--;
      end else if (b == 8'h0C) begin
         exp_clr++;
         m_col = 0;
         m_row = 0;
      end
   endtask

   task automatic send(input logic [7:0] b);
      int n = 0;
      @(negedge clk);
      while (!char_ready && n < 1500) begin
         n++;
         @(negedge clk);
      end
      if (!char_ready) chk("send_timeout", n, 0);
      char_data  = b;
      char_valid = 1'b1;
      model_accept(b);
      @(posedge clk);
      #1;
      char_valid = 1'b0;
      char_data  = 8'($urandom);
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      @(negedge clk);
      while ((busy || !char_ready) && n < 1500) begin
         n++;
         @(negedge clk);
      end
      if (busy) chk({name, "_idle_timeout"}, int'(busy), 0);
   endtask

   task automatic check_writes(input string name);
      logic [17:0] g, e;
      chk({name, "_nwrites"}, got_q.size(), exp_q.size());
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front();
         e = exp_q.pop_front();
         chk({name, "_write"}, int'(g), int'(e));
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic check_cursor(input string name, input int col, input int row);
      chk({name, "_col"}, int'(cursor_col), col);
      chk({name, "_row"}, int'(cursor_row), row);
   endtask

   initial begin
      int vs_before, clr_before, bc, n, r;
      logic [7:0] b;
      tbl[0]  = '{8'h0D, 0, 0, 0, 0, 0};
      tbl[1]  = '{8'h0A, 0, 1, 0, 0, 0};
      tbl[2]  = '{8'h42, 1, 1, 1, 40, 8'h42};
      tbl[3]  = '{8'h08, 0, 1, 0, 0, 0};
      tbl[4]  = '{8'h08, 0, 1, 0, 0, 0};
      tbl[5]  = '{8'h07, 0, 1, 0, 0, 0};
      tbl[6]  = '{8'h7E, 1, 1, 1, 40, 8'h7E};
      tbl[7]  = '{8'h1B, 1, 1, 0, 0, 0};
      tbl[8]  = '{8'h0A, 1, 2, 0, 0, 0};
      tbl[9]  = '{8'h20, 2, 2, 1, 81, 8'h20};
      tbl[10] = '{8'hFF, 3, 2, 1, 82, 8'hFF};
      burst[0] = 8'h08; burst[1] = 8'h08; burst[2] = 8'h0D; burst[3] = 8'h0A; burst[4] = 8'h07;

      rst_n = 1'b0; char_valid = 1'b0; char_data = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst_ready", int'(char_ready), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_we", int'(video_we), 0);
      chk("rst_addr", int'(video_addr), 0);
      rst_n = 1'b1;
      @(negedge clk);
      check_cursor("rst", 0, 0);
      chk("rst_vscroll", int'(video_vscroll), 0);
      chk("rst_clear", int'(video_clear), 0);

      // First printable byte: exact per-cycle latency
      chk("lat_ready_before", int'(char_ready), 1);
      char_data = 8'h41; char_valid = 1'b1; model_accept(8'h41);
      @(posedge clk); #1; char_valid = 1'b0;
      chk("lat_ready_during", int'(char_ready), 0);
      chk("lat_we", int'(video_we), 1);
      chk("lat_addr", int'(video_addr), 0);
      chk("lat_data", int'(video_data), 8'h41);
      @(posedge clk); #1;
      chk("lat_ready_after", int'(char_ready), 1);
      chk("lat_we_after", int'(video_we), 0);
      check_cursor("lat", 1, 0);
      check_writes("lat");

      for (int i = 0; i < 11; i++) begin
         send(tbl[i].ch);
         wait_idle("tbl");
         check_cursor("tbl", tbl[i].col, tbl[i].row);
         chk("tbl_nw", got_q.size(), tbl[i].nw);
         if (tbl[i].nw > 0 && got_q.size() > 0) begin
            chk("tbl_addr", int'(got_q[0][17:8]), tbl[i].addr);
            chk("tbl_data", int'(got_q[0][7:0]), tbl[i].data);
         end
         check_writes("tbl_model");
      end

      // Back-to-back control codes from (5,2)
      send(8'h61); send(8'h62); wait_idle("pre_burst");
      check_cursor("pre_burst", 5, 2);
      check_writes("pre_burst");
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         char_data = burst[i]; char_valid = 1'b1;
         chk("burst_ready", int'(char_ready), 1);
         model_accept(burst[i]);
         @(posedge clk); #1;
      end
      char_valid = 1'b0;
      wait_idle("burst");
      check_cursor("burst", 0, 3);
      chk("burst_nw", got_q.size(), 0);
      check_writes("burst");

      // Wrap at col 39 without scrolling
      for (int i = 0; i < 39; i++) send(8'h30 + 8'(i % 10));
      wait_idle("pre_wrap");
      check_writes("pre_wrap");
      vs_before = vs_cnt;
      send(8'h5A); wait_idle("wrap");
      chk("wrap_nw", got_q.size(), 1);
      if (got_q.size() > 0) chk("wrap_write", int'(got_q[0]), int'({10'd159, 8'h5A}));
      chk("wrap_vscroll", vs_cnt - vs_before, 0);
      check_cursor("wrap", 0, 4);
      check_writes("wrap");

      // Form feed from (12,10)
      repeat (6) send(8'h0A);
      for (int i = 0; i < 12; i++) send(8'h41);
      wait_idle("pre_ff");
      check_cursor("pre_ff", 12, 10);
      check_writes("pre_ff");
      clr_before = clr_cnt;
      send(8'h0C);
      bc = 0;
      @(negedge clk);
      while (busy && bc < 1500) begin
         bc++;
         @(negedge clk);
      end
      chk("ff_busy_cycles", bc, 1003);
      chk("ff_clear_pulse", clr_cnt - clr_before, 1);
      check_cursor("ff", 0, 0);
      check_writes("ff");

      // Drive base to 960, then scroll from (39,24) across the ring wrap
      repeat (48) send(8'h0A);
      send(8'h0D);
      for (int i = 0; i < 39; i++) send(8'h61 + 8'(i % 26));
      wait_idle("pre_scroll");
      check_cursor("pre_scroll", 39, 24);
      check_writes("pre_scroll");
      vs_before = vs_cnt;
      send(8'h31); wait_idle("scroll");
      chk("scroll_nw", got_q.size(), 41);
      if (got_q.size() >= 41) begin
         chk("scroll_char", int'(got_q[0]), int'({10'd959, 8'h31}));
         for (int c = 0; c < 40; c++)
            chk("scroll_fill", int'(got_q[1 + c]), int'({10'(960 + c), 8'h00}));
      end
      chk("scroll_vscroll", vs_cnt - vs_before, 4);
      check_cursor("scroll", 0, 24);
      check_writes("scroll_model");
      send(8'h41); wait_idle("post_scroll");
      chk("base_wrap_nw", got_q.size(), 1);
      if (got_q.size() > 0) chk("base_wrap_addr", int'(got_q[0][17:8]), 960);
      check_writes("post_scroll");

      // Asynchronous reset in the middle of a line clear
      for (int i = 0; i < 38; i++) send(8'h62);
      wait_idle("pre_rst");
      check_writes("pre_rst");
      send(8'h33);
      n = 0;
      while (got_q.size() < 21 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("lclr_reached", int'(got_q.size() >= 21), 1);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("arst_ce", int'(video_ce), 0);
      chk("arst_we", int'(video_we), 0);
      chk("arst_addr", int'(video_addr), 0);
      chk("arst_data", int'(video_data), 0);
      chk("arst_vscroll", int'(video_vscroll), 0);
      chk("arst_clear", int'(video_clear), 0);
      chk("arst_ready", int'(char_ready), 1);
      chk("arst_busy", int'(busy), 0);
      check_cursor("arst", 0, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      m_col = 0; m_row = 0; m_base = 0;
      got_q.delete(); exp_q.delete();
      repeat (3) @(negedge clk);
      chk("post_rst_ready", int'(char_ready), 1);
      chk("post_rst_busy", int'(busy), 0);
      send(8'h41); wait_idle("post_rst");
      chk("post_rst_nw", got_q.size(), 1);
      if (got_q.size() > 0) chk("post_rst_addr", int'(got_q[0][17:8]), 0);
      check_writes("post_rst");

      // Random byte stream against the reference model
      for (int i = 0; i < 400; i++) begin
         r = $urandom_range(0, 99);
         if (r < 50) b = 8'($urandom_range(32, 255));
         else if (r < 70) b = 8'h0A;
         else if (r < 78) b = 8'h0D;
         else if (r < 86) b = 8'h08;
         else if (r < 99) b = 8'($urandom_range(0, 31));
         else b = 8'h0C;
         send(b);
         wait_idle("rnd");
         check_cursor("rnd", m_col, m_row);
         check_writes("rnd");
      end
      chk("total_vscroll_cycles", vs_cnt, exp_vs);
      chk("total_clear_pulses", clr_cnt, exp_clr);
      chk("idle_bus_quiet", bad_idle, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/video_term_ctrl.md
# video_term_ctrl

Character-terminal controller sitting between the AIM-65 CPU-side display path and the 40x25 video character RAM write port. Accepts a byte stream over a valid/ready handshake, keeps the cursor and the scroll ring base, and turns printable bytes and control codes into RAM writes, `video_vscroll` pulses, bottom-line clears and full-screen clears. All sequencing is in the CPU clock domain. The video block consumes its outputs directly.

## Interface
- `COLS`, 40: characters per row.
- `ROWS`, 25: rows per screen.
- `RAM_SIZE`, 1000: character RAM size, equal to `COLS*ROWS`.
- `FILL_CHAR`, 8'h00: byte written by line clears.
- `VSCROLL_CYCLES`, 4: width of the `video_vscroll` pulse. It spans at least 2 pixel-domain samples.
- `CLEAR_CYCLES`, 1002: busy time after a `video_clear` pulse.
- `cpu_clk`, in, 1: the only clock. Everything is rising-edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `char_valid`, in, 1: an input byte is offered.
- `char_data`, in, 8: the input byte.
- `char_ready`, out, 1: the controller can accept a byte.
- `video_ce`, out, 1: RAM chip enable.
- `video_we`, out, 1: RAM write enable.
- `video_addr`, out, 10: RAM write address.
- `video_data`, out, 8: RAM write data.
- `video_vscroll`, out, 1: scroll request to the video block. It is level-high for `VSCROLL_CYCLES`.
- `video_clear`, out, 1: full-clear request, a 1-cycle pulse.
- `cursor_col`, out, 6: current column, 0..39.
- `cursor_row`, out, 5: current row, 0..24.
- `busy`, out, 1: high in every state except IDLE.

## Operation
- **States:** IDLE, WRITE, SCROLL, LCLR, CLEAR.
- `char_ready` equals (state==IDLE). A byte is accepted on a cycle with `char_valid & char_ready`.
- **Address arithmetic:** `lin = base + row*40 + col`, computed in 11 bits. If `lin >= 1000`, subtract 1000. The result goes to `video_addr`.
- `base` is in {0, 40, ..., 960}. Its reset value is 0.
- **Byte decode at acceptance:**
  - **>= 0x20:** latch the byte, then go to WRITE.
  - **0x0D (CR):** set col=0. Stay in IDLE.
  - **0x0A (LF):** perform NEWLINE.
  - **0x08 (BS):** if col>0, decrement col. If col==0, do nothing. No write is issued.
  - **0x0C (FF):** go to CLEAR.
  - **Any other byte < 0x20:** consumed and ignored.
- **WRITE:** a 1-cycle write with `video_ce=video_we=1`, `video_addr` at the cursor, `video_data` equal to the byte.
  - Next, if col<39: col+1, return to IDLE.
  - If col==39: col=0, then perform NEWLINE.
- **NEWLINE:**
  - If row<24: row+1, go to IDLE.
  - If row==24: go to SCROLL. row stays 24.
- **SCROLL:** `video_vscroll=1` for `VSCROLL_CYCLES` cycles. On the last of those cycles, `base <= (base==960) ? 0 : base+40`. Then go to LCLR.
- **LCLR:** 40 consecutive write cycles with data `FILL_CHAR`, covering col 0..39 of row 24 using the new base. Then go to IDLE.
- **CLEAR:**
  - Drive `video_clear=1` for the first cycle.
  - Then hold for `CLEAR_CYCLES` cycles with a down-counter.
  - Set cursor to (0,0). `base` is unchanged.
  - Then go to IDLE.
- **Outputs outside write cycles:** `video_ce`, `video_we` and `video_data` are 0, and `video_addr` holds its last value.

## Timing
- **Reset values:** state IDLE, `char_ready=1`, `busy=0`. All video outputs are 0. Cursor is (0,0) and `base=0`.
- **Reset mid-operation:** `reset_n` low aborts any state immediately and asynchronously. Every register returns to its reset value, and a half-done scroll or clear is abandoned.
- **Printable byte latency:** accepted at cycle 0, written at cycle 1, `char_ready` high again at cycle 2. Maximum throughput is 1 byte every 2 cycles.
- **Control-byte latency:** CR, BS, ignored codes and non-scrolling LF take 1 cycle. `char_ready` stays high, so back-to-back acceptance is allowed.
- **Scroll cost:** a write at (39,24) costs 1 + `VSCROLL_CYCLES` + 40 cycles from the write to the return to IDLE.
- **FF cost:** 1 + `CLEAR_CYCLES` cycles of busy.
- `char_data` is sampled only at acceptance. It may change freely otherwise.
- Every output is registered, except `char_ready` and `busy`, which decode from the state register.

## Test plan
- **Reset, then write:** release reset, send 0x41. Expect one write at addr 0 with data 0x41, cursor (1,0), `char_ready` low for exactly 1 cycle.
- **Wrap without scroll:** cursor (39,3), send 0x5A. Expect a write at addr 159, then cursor (0,4), no `video_vscroll`.
- **Scroll with ring wrap:** `base`=960, cursor (39,24), send 0x31. Expect:
  - a write at addr `(960+999) mod 1000` = 959;
  - `video_vscroll` high for 4 cycles;
  - 40 writes of 0x00 to addr 960..999;
  - `base`=0, cursor (0,24).
- **Control codes:** at cursor (5,2), send 0x08 0x08 0x0D 0x0A 0x07. Expect cursor (0,3), no RAM writes, 5 consecutive acceptances.
- **Form feed:** from (12,10), send 0x0C. Expect `video_clear` high for exactly 1 cycle, `busy` for 1003 cycles, cursor (0,0), `base` unchanged.
- **Async reset mid-LCLR:** assert `reset_n` low after the 20th fill write. Expect all outputs at reset values in the same cycle, and state IDLE after release.
